nt35510_bus_responder: RTL and testbench

Panel-side responder for the NT35510 8080-style 16-bit parallel LCD bus, i.e. the device end of the bus driven by our NT35510 APB host controller. It samples the asynchronous bus strobes, decodes DCS command/parameter writes, and maintains a column/page window and display-state registers. During RAMWR it emits one addressed pixel per data write and answers ID/status reads. Used as an on-chip panel emulator for loopback bring-up and as the bus-level checker in system simulation.

---
 rtl/nt35510_bus_responder.sv | 213 +++++++++++++++++++++
 tb/tb_nt35510_bus_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nt35510_bus_responder.sv
// Device-side responder for the NT35510 8080-style 16-bit LCD bus: decodes DCS writes,
// tracks the column/page window, streams RAMWR pixels and answers ID/status reads.
module nt35510_bus_responder #(
  parameter int unsigned H_RES = 480,
  parameter int unsigned V_RES = 800,
  parameter logic [7:0]  ID1   = 8'h00,
  parameter logic [7:0]  ID2   = 8'h80,
  parameter logic [7:0]  ID3   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_csel,
  input  logic        LCD_rs,
  input  logic        LCD_wr,
  input  logic        LCD_rd,
  input  logic [15:0] LCD_data_in,
  output logic [15:0] LCD_data_out,
  output logic        LCD_data_oe,
  output logic        PIX_valid,
  output logic        PIX_first,
  output logic [15:0] PIX_x,
  output logic [15:0] PIX_y,
  output logic [15:0] PIX_data,
  output logic        disp_on,
  output logic        sleep_out
);

  localparam logic [15:0] XE_DEF = 16'(H_RES - 1);
  localparam logic [15:0] YE_DEF = 16'(V_RES - 1);

  localparam logic [15:0] CMD_SLPIN  = 16'h1000;
  localparam logic [15:0] CMD_SLPOUT = 16'h1100;
  localparam logic [15:0] CMD_DISPOF = 16'h2800;
  localparam logic [15:0] CMD_DISPON = 16'h2900;
  localparam logic [15:0] CMD_CASET0 = 16'h2A00;
  localparam logic [15:0] CMD_CASET1 = 16'h2A01;
  localparam logic [15:0] CMD_CASET2 = 16'h2A02;
  localparam logic [15:0] CMD_CASET3 = 16'h2A03;
  localparam logic [15:0] CMD_PASET0 = 16'h2B00;
  localparam logic [15:0] CMD_PASET1 = 16'h2B01;
  localparam logic [15:0] CMD_PASET2 = 16'h2B02;
  localparam logic [15:0] CMD_PASET3 = 16'h2B03;
  localparam logic [15:0] CMD_RAMWR  = 16'h2C00;
  localparam logic [15:0] CMD_RDDPM  = 16'h0A00;
  localparam logic [15:0] CMD_RDID1  = 16'hDA00;
  localparam logic [15:0] CMD_RDID2  = 16'hDB00;
  localparam logic [15:0] CMD_RDID3  = 16'hDC00;

  typedef enum logic [1:0] {IDLE, SELECTED, READ_DRIVE} state_t;

  // Strobe vector bit order: [3]=rd, [2]=wr, [1]=rs, [0]=csel; idle bus is 4'b1101.
  localparam logic [3:0] BUS_IDLE = 4'b1101;

  state_t      state;
  logic [3:0]  sync1, sync2;
  logic [3:0]  hist;
  logic [15:0] data1, data2;

  logic [15:0] cur_cmd;
  logic [15:0] xs, xe, ys, ye;
  logic [15:0] cur_x, cur_y;
  logic        first_armed;

  logic        sel, rs;
  logic        wr_rise, rd_fall, rd_rise, csel_fall, csel_rise;
  logic [15:0] nx_x, nx_y;
  logic [15:0] read_word;

  assign sel       = ~sync2[0];
  assign rs        = sync2[1];
  assign wr_rise   = sel & sync2[2] & ~hist[2];
  assign rd_fall   = sel & ~sync2[3] & hist[3];
  assign rd_rise   = sync2[3] & ~hist[3];
  assign csel_fall = ~sync2[0] & hist[0];
  assign csel_rise = sync2[0] & ~hist[0];

  // The >= tests make a window that shrank under the cursor wrap instead of running away.
  always_comb begin
    nx_x = cur_x + 16'd1;
    nx_y = cur_y;
    if (cur_x >= xe) begin
      nx_x = xs;
      nx_y = (cur_y >= ye) ? ys : (cur_y + 16'd1);
    end
  end

  always_comb begin
    read_word = 16'h0000;
    case (cur_cmd)
      CMD_RDID1: read_word = {8'h00, ID1};
      CMD_RDID2: read_word = {8'h00, ID2};
      CMD_RDID3: read_word = {8'h00, ID3};
      CMD_RDDPM: read_word = {8'h00, sleep_out, 2'b00, sleep_out, 1'b0, disp_on, 2'b00};
      default:   read_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sync1        <= BUS_IDLE;
      sync2        <= BUS_IDLE;
      hist         <= BUS_IDLE;
      data1        <= 16'h0000;
      data2        <= 16'h0000;
      cur_cmd      <= 16'h0000;
      xs           <= 16'h0000;
      xe           <= XE_DEF;
      ys           <= 16'h0000;
      ye           <= YE_DEF;
      cur_x        <= 16'h0000;
      cur_y        <= 16'h0000;
      first_armed  <= 1'b0;
      LCD_data_out <= 16'h0000;
      LCD_data_oe  <= 1'b0;
      PIX_valid    <= 1'b0;
      PIX_first    <= 1'b0;
      PIX_x        <= 16'h0000;
      PIX_y        <= 16'h0000;
      PIX_data     <= 16'h0000;
      disp_on      <= 1'b0;
      sleep_out    <= 1'b0;
    end else begin
      sync1     <= {LCD_rd, LCD_wr, LCD_rs, LCD_csel};
      sync2     <= sync1;
      hist      <= sync2;
      data1     <= LCD_data_in;
      data2     <= data1;
      PIX_valid <= 1'b0;
      PIX_first <= 1'b0;

      // Read-side bus ownership; the write decode below runs independently of it.
      case (state)
        IDLE: begin
          if (csel_fall) begin
            if (rd_fall) begin
              LCD_data_oe  <= 1'b1;
              LCD_data_out <= read_word;
              state        <= READ_DRIVE;
            end else begin
              state <= SELECTED;
            end
          end
        end
        SELECTED: begin
          if (csel_rise || !sel) begin
            state <= IDLE;
          end else if (rd_fall) begin
            LCD_data_oe  <= 1'b1;
            LCD_data_out <= read_word;
            state        <= READ_DRIVE;
          end
        end
        READ_DRIVE: begin
          if (csel_rise || !sel) begin
            LCD_data_oe  <= 1'b0;
            LCD_data_out <= 16'h0000;
            state        <= IDLE;
          end else if (rd_rise) begin
            LCD_data_oe  <= 1'b0;
            LCD_data_out <= 16'h0000;
            state        <= SELECTED;
          end
        end
        default: begin
          LCD_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase

      if (wr_rise) begin
        if (!rs) begin
          cur_cmd <= data2;
          case (data2)
            CMD_SLPOUT: sleep_out <= 1'b1;
            CMD_SLPIN:  sleep_out <= 1'b0;
            CMD_DISPON: disp_on   <= 1'b1;
            CMD_DISPOF: disp_on   <= 1'b0;
            CMD_RAMWR: begin
              cur_x       <= xs;
              cur_y       <= ys;
              first_armed <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          case (cur_cmd)
            CMD_CASET0: xs[15:8] <= data2[7:0];
            CMD_CASET1: xs[7:0]  <= data2[7:0];
            CMD_CASET2: xe[15:8] <= data2[7:0];
            CMD_CASET3: xe[7:0]  <= data2[7:0];
            CMD_PASET0: ys[15:8] <= data2[7:0];
            CMD_PASET1: ys[7:0]  <= data2[7:0];
            CMD_PASET2: ye[15:8] <= data2[7:0];
            CMD_PASET3: ye[7:0]  <= data2[7:0];
            CMD_RAMWR: begin
              PIX_valid   <= 1'b1;
              PIX_first   <= first_armed;
              PIX_x       <= cur_x;
              PIX_y       <= cur_y;
              PIX_data    <= data2;
              first_armed <= 1'b0;
              cur_x       <= nx_x;
              cur_y       <= nx_y;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nt35510_bus_responder.sv
// Directed bench for nt35510_bus_responder: drives 8080-style bus cycles and checks
// pixels, window wrap, status/ID reads, csel gating and mid-transaction reset.
module tb_nt35510_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LCD_csel = 1'b1;
  logic        LCD_rs = 1'b0;
  logic        LCD_wr = 1'b1;
  logic        LCD_rd = 1'b1;
  logic [15:0] LCD_data_in = 16'h0000;
  logic [15:0] LCD_data_out;
  logic        LCD_data_oe;
  logic        PIX_valid;
  logic        PIX_first;
  logic [15:0] PIX_x;
  logic [15:0] PIX_y;
  logic [15:0] PIX_data;
  logic        disp_on;
  logic        sleep_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] qx[$];
  logic [15:0] qy[$];
  logic [15:0] qd[$];
  logic        qf[$];

  nt35510_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .LCD_csel     (LCD_csel),
    .LCD_rs       (LCD_rs),
    .LCD_wr       (LCD_wr),
    .LCD_rd       (LCD_rd),
    .LCD_data_in  (LCD_data_in),
    .LCD_data_out (LCD_data_out),
    .LCD_data_oe  (LCD_data_oe),
    .PIX_valid    (PIX_valid),
    .PIX_first    (PIX_first),
    .PIX_x        (PIX_x),
    .PIX_y        (PIX_y),
    .PIX_data     (PIX_data),
    .disp_on      (disp_on),
    .sleep_out    (sleep_out)
  );

  always #5 clk = ~clk;

  // Every cycle PIX_valid is high lands in the pixel log, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (PIX_valid === 1'b1) begin
      qx.push_back(PIX_x);
      qy.push_back(PIX_y);
      qd.push_back(PIX_data);
      qf.push_back(PIX_first);
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    qx.delete();
    qy.delete();
    qd.delete();
    qf.delete();
  endtask

  task automatic bus_write(input logic rs, input logic [15:0] d);
    LCD_rs      = rs;
    LCD_data_in = d;
    LCD_wr      = 1'b0;
    step(3);
    LCD_wr = 1'b1;
    step(6);
  endtask

  task automatic set_window(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1);
    bus_write(1'b0, 16'h2A00); bus_write(1'b1, {8'h00, x0[15:8]});
    bus_write(1'b0, 16'h2A01); bus_write(1'b1, {8'h00, x0[7:0]});
    bus_write(1'b0, 16'h2A02); bus_write(1'b1, {8'h00, x1[15:8]});
    bus_write(1'b0, 16'h2A03); bus_write(1'b1, {8'h00, x1[7:0]});
    bus_write(1'b0, 16'h2B00); bus_write(1'b1, {8'h00, y0[15:8]});
    bus_write(1'b0, 16'h2B01); bus_write(1'b1, {8'h00, y0[7:0]});
    bus_write(1'b0, 16'h2B02); bus_write(1'b1, {8'h00, y1[15:8]});
    bus_write(1'b0, 16'h2B03); bus_write(1'b1, {8'h00, y1[7:0]});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(4);
    @(negedge clk);
    n_cmp++; if (LCD_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_oe got %b want 0", LCD_data_oe); end
    n_cmp++; if (PIX_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pix_valid got %b want 0", PIX_valid); end
    n_cmp++; if ({disp_on, sleep_out} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_state got %b want 00", {disp_on, sleep_out}); end
    n_cmp++; if (LCD_data_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_data_out got %h want 0000", LCD_data_out); end
    rst = 1'b0;
    step(2);
    LCD_csel = 1'b0;
    step(3);
    clear_log();
    bus_write(1'b0, 16'h2C00);
    bus_write(1'b1, 16'hABCD);
    n_cmp++;
    if (qx.size() != 1) begin
      n_fail++; $display("[TB] FAIL reset_ramwr_count got %0d want 1", qx.size());
    end else if ({qx[0], qy[0], qd[0], qf[0]} !== {16'd0, 16'd0, 16'hABCD, 1'b1}) begin
      n_fail++; $display("[TB] FAIL reset_ramwr_pixel got x=%0d y=%0d d=%h f=%b want x=0 y=0 d=abcd f=1",
                         qx[0], qy[0], qd[0], qf[0]);
    end
  endtask

  task automatic test_window();
    logic [15:0] ex[6] = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11, 16'd12};
    logic [15:0] ey[6] = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd6, 16'd6};
    set_window(16'd10, 16'd12, 16'd5, 16'd6);
    clear_log();
    bus_write(1'b0, 16'h2C00);
    for (int i = 0; i < 6; i++) bus_write(1'b1, 16'h1111 * 16'(i + 1));
    n_cmp++; if (qx.size() != 6) begin n_fail++; $display("[TB] FAIL window_count got %0d want 6", qx.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < qx.size()) begin
        n_cmp++;
        if ({qx[i], qy[i], qd[i], qf[i]} !== {ex[i], ey[i], 16'h1111 * 16'(i + 1), (i == 0)}) begin
          n_fail++; $display("[TB] FAIL window_pix%0d got x=%0d y=%0d d=%h f=%b want x=%0d y=%0d d=%h f=%b",
                             i, qx[i], qy[i], qd[i], qf[i], ex[i], ey[i], 16'h1111 * 16'(i + 1), (i == 0));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ex[7] = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11, 16'd12, 16'd10};
    logic [15:0] ey[7] = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd6, 16'd6, 16'd5};
    clear_log();
    bus_write(1'b0, 16'h2C00);
    for (int i = 0; i < 7; i++) bus_write(1'b1, 16'h0101 * 16'(i + 1));
    n_cmp++; if (qx.size() != 7) begin n_fail++; $display("[TB] FAIL wrap_count got %0d want 7", qx.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < qx.size()) begin
        n_cmp++;
        if ({qx[i], qy[i], qd[i], qf[i]} !== {ex[i], ey[i], 16'h0101 * 16'(i + 1), (i == 0)}) begin
          n_fail++; $display("[TB] FAIL wrap_pix%0d got x=%0d y=%0d d=%h f=%b want x=%0d y=%0d f=%b",
                             i, qx[i], qy[i], qd[i], qf[i], ex[i], ey[i], (i == 0));
        end
      end
    end
  endtask

  task automatic test_status_read();
    bus_write(1'b0, 16'h1100);
    bus_write(1'b0, 16'h2900);
    n_cmp++; if ({sleep_out, disp_on} !== 2'b11) begin n_fail++; $display("[TB] FAIL status_flags got %b want 11", {sleep_out, disp_on}); end
    bus_write(1'b0, 16'h0A00);
    LCD_rd = 1'b0;
    step(5);
    @(negedge clk);
    n_cmp++; if (LCD_data_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL rddpm_oe got %b want 1", LCD_data_oe); end
    n_cmp++; if (LCD_data_out !== 16'h0094) begin n_fail++; $display("[TB] FAIL rddpm_data got %h want 0094", LCD_data_out); end
    LCD_csel = 1'b1;
    step(5);
    @(negedge clk);
    n_cmp++; if (LCD_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL rddpm_csel_release got %b want 0", LCD_data_oe); end
    LCD_rd = 1'b1;
    step(3);
    LCD_csel = 1'b0;
    step(3);
  endtask

  task automatic test_id_and_csel();
    bus_write(1'b0, 16'hDB00);
    LCD_rd = 1'b0;
    step(5);
    @(negedge clk);
    n_cmp++; if ({LCD_data_oe, LCD_data_out} !== {1'b1, 16'h0080}) begin n_fail++; $display("[TB] FAIL rdid2 got oe=%b d=%h want oe=1 d=0080", LCD_data_oe, LCD_data_out); end
    LCD_rd = 1'b1;
    step(5);
    @(negedge clk);
    n_cmp++; if (LCD_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL rdid2_rd_release got %b want 0", LCD_data_oe); end
    bus_write(1'b0, 16'h2A00);
    LCD_rd = 1'b0;
    step(5);
    @(negedge clk);
    n_cmp++; if ({LCD_data_oe, LCD_data_out} !== {1'b1, 16'h0000}) begin n_fail++; $display("[TB] FAIL other_read got oe=%b d=%h want oe=1 d=0000", LCD_data_oe, LCD_data_out); end
    LCD_rd = 1'b1;
    step(5);
    LCD_csel = 1'b1;
    step(3);
    bus_write(1'b0, 16'h2800);
    bus_write(1'b0, 16'h1000);
    n_cmp++; if ({sleep_out, disp_on} !== 2'b11) begin n_fail++; $display("[TB] FAIL csel_high_write got %b want 11", {sleep_out, disp_on}); end
    LCD_csel = 1'b0;
    step(3);
  endtask

  task automatic test_reset_mid();
    bus_write(1'b0, 16'hDB00);
    LCD_rd = 1'b0;
    step(5);
    n_cmp++; if (LCD_data_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_oe got %b want 1", LCD_data_oe); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (LCD_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_oe got %b want 0", LCD_data_oe); end
    LCD_rd = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    bus_write(1'b0, 16'h2C00);
    clear_log();
    LCD_rs      = 1'b1;
    LCD_data_in = 16'hBEEF;
    LCD_wr      = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    LCD_wr = 1'b1;
    step(6);
    n_cmp++; if (qx.size() != 0) begin n_fail++; $display("[TB] FAIL reset_mid_pix got %0d pixels want 0", qx.size()); end
    n_cmp++; if ({sleep_out, disp_on} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_mid_state got %b want 00", {sleep_out, disp_on}); end
    bus_write(1'b0, 16'h2C00);
    for (int i = 0; i < 481; i++) bus_write(1'b1, 16'(i));
    n_cmp++;
    if (qx.size() != 481) begin
      n_fail++; $display("[TB] FAIL default_window_count got %0d want 481", qx.size());
    end else begin
      n_cmp++; if ({qx[0], qy[0], qf[0]} !== {16'd0, 16'd0, 1'b1}) begin n_fail++; $display("[TB] FAIL default_first got x=%0d y=%0d f=%b want 0 0 1", qx[0], qy[0], qf[0]); end
      n_cmp++; if ({qx[479], qy[479], qd[479]} !== {16'd479, 16'd0, 16'd479}) begin n_fail++; $display("[TB] FAIL default_xe got x=%0d y=%0d d=%h want 479 0 01df", qx[479], qy[479], qd[479]); end
      n_cmp++; if ({qx[480], qy[480], qf[480]} !== {16'd0, 16'd1, 1'b0}) begin n_fail++; $display("[TB] FAIL default_row_wrap got x=%0d y=%0d f=%b want 0 1 0", qx[480], qy[480], qf[480]); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_window();
    test_wrap();
    test_status_read();
    test_id_and_csel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
